// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI bus arbiter and the devices on its bus.
package pci_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_BUSY,
        ARB_TURN
    } arb_state_e;

    localparam logic [3:0]  WRITE_C_BE = 4'b0011;
    localparam logic [3:0]  READ_C_BE  = 4'b0010;

    localparam logic [31:0] DEV_A_ADDR = 32'hAD;
    localparam logic [31:0] DEV_B_ADDR = 32'hBD;
    localparam logic [31:0] DEV_C_ADDR = 32'hCD;

    // Next master index after idx, wrapping from n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pci_bus_arbiter_if.sv
// Arbitration signals of the shared PCI bus: active-low REQ/GNT per master plus FRAME/IRDY.
interface pci_bus_arbiter_if #(
    parameter int NUM_MASTERS = 3
);
    logic [NUM_MASTERS-1:0] REQ;
    logic [NUM_MASTERS-1:0] GNT;
    logic                   FRAME;
    logic                   IRDY;

    // master: the arbiter side; slave: the requesting devices.
    modport master (input REQ, input FRAME, input IRDY, output GNT);
    modport slave  (output REQ, output FRAME, output IRDY, input GNT);
endinterface

// File: rtl/pci_bus_arbiter_picker.sv
// Round-robin priority encoder: first active request at or after ptr, searching upward with wrap.
module pci_rr_picker #(
    parameter  int N = 3,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         valid
);

    logic [W-1:0] cand [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [W:0] sum;
        assign sum       = {1'b0, ptr} + (W+1)'(gi);
        assign cand[gi]  = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
    end

    // Scan from the farthest candidate down so the nearest one to ptr wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                winner = cand[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin grants, turnaround insertion, unused-grant timeout.
// Optional bus parking on the last owner is enabled by defining PCI_ARB_BUS_PARK_EN.
module pci_bus_arbiter
    import pci_pkg::*;
#(
    parameter  int NUM_MASTERS = 3,
    parameter  int GNT_TIMEOUT = 16,
    localparam int OWN_W       = $clog2(NUM_MASTERS),
    localparam int CNT_W       = $clog2(GNT_TIMEOUT) + 1
) (
    input  logic              clk,
    input  logic              RST,
    pci_bus_arbiter_if.master bus,
    output logic [OWN_W-1:0]  owner,
    output logic              bus_busy,
    output logic              timeout_pulse
);

    localparam logic [NUM_MASTERS-1:0] ALL_HIGH = '1;

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [OWN_W-1:0]       owner_q, owner_d;
    logic [OWN_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   pulse_q, pulse_d;

    logic [NUM_MASTERS-1:0] req_act;
    logic [OWN_W-1:0]       winner;
    logic                   win_valid;
    logic                   bus_idle;
    logic [OWN_W-1:0]       ptr_after_owner;

    function automatic logic [NUM_MASTERS-1:0] one_cold(input logic [OWN_W-1:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v      = '1;
        v[idx] = 1'b0;
        return v;
    endfunction

    assign req_act         = ~bus.REQ;
    assign bus_idle        = bus.FRAME & bus.IRDY;
    assign ptr_after_owner = OWN_W'(wrap_inc(int'(owner_q), NUM_MASTERS));

    pci_rr_picker #(.N(NUM_MASTERS)) u_picker (
        .req    (req_act),
        .ptr    (ptr_q),
        .winner (winner),
        .valid  (win_valid)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        busy_d  = ~bus.FRAME | ~bus.IRDY;
        unique case (state_q)
            ARB_IDLE: begin
                gnt_d = ALL_HIGH;
                if (win_valid && bus_idle) begin
`ifdef PCI_ARB_BUS_PARK_EN
                    // Parked on a different master: release the bus for one clock first.
                    if (gnt_q != ALL_HIGH && winner != owner_q) begin
                        gnt_d = ALL_HIGH;
                    end else begin
                        state_d = ARB_GRANT;
                        gnt_d   = one_cold(winner);
                        owner_d = winner;
                        cnt_d   = '0;
                    end
`else
                    state_d = ARB_GRANT;
                    gnt_d   = one_cold(winner);
                    owner_d = winner;
                    cnt_d   = '0;
`endif
                end
`ifdef PCI_ARB_BUS_PARK_EN
                else if (!win_valid) begin
                    gnt_d = one_cold(owner_q);
                end
`endif
            end
            ARB_GRANT: begin
                if (!bus.FRAME) begin
                    state_d = ARB_BUSY;
                end else if (bus.REQ[owner_q]) begin
                    state_d = ARB_IDLE;
                    gnt_d   = ALL_HIGH;
                    ptr_d   = ptr_after_owner;
                end else if (cnt_q == CNT_W'(GNT_TIMEOUT - 1)) begin
                    state_d = ARB_IDLE;
                    gnt_d   = ALL_HIGH;
                    ptr_d   = ptr_after_owner;
                    pulse_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_BUSY: begin
                if (bus_idle) begin
                    state_d = ARB_TURN;
                    gnt_d   = ALL_HIGH;
                    ptr_d   = ptr_after_owner;
                end
            end
            ARB_TURN: begin
                state_d = ARB_IDLE;
                gnt_d   = ALL_HIGH;
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = ALL_HIGH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q <= ARB_IDLE;
            gnt_q   <= ALL_HIGH;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.GNT       = gnt_q;
    assign owner         = owner_q;
    assign bus_busy      = busy_q;
    assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Scoreboard bench for pci_bus_arbiter: stimulus queues expected GNT/pulse changes with their edge number.
module tb_pci_bus_arbiter;

    localparam int NM = 3;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       RST;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout_pulse;

    pci_bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

    pci_bus_arbiter #(.NUM_MASTERS(NM), .GNT_TIMEOUT(TO)) dut (
        .clk           (clk),
        .RST           (RST),
        .bus           (bus),
        .owner         (owner),
        .bus_busy      (bus_busy),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_no;
        logic [2:0] gnt;
        logic       pulse;
        logic [1:0] own;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   bad    = 0;
    int   edge_n = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int e, input logic [2:0] gv, input logic p, input logic [1:0] o);
        exp_t x;
        x.edge_no = e;
        x.gnt     = gv;
        x.pulse   = p;
        x.own     = o;
        exp_q.push_back(x);
    endtask

    // Called on the edge a grant appeared; runs a len-clock transaction and waits out TURN.
    task automatic txn(input int len, input logic [1:0] own,
                       input logic [2:0] next_gnt, input logic [1:0] next_own);
        int g;
        g = edge_n;
        push(g + len + 1, 3'b111, 1'b0, own);
        if (next_gnt != 3'b111) push(g + len + 3, next_gnt, 1'b0, next_own);
        bus.FRAME = 1'b0;
        bus.IRDY  = 1'b0;
        step(len);
        bus.FRAME = 1'b1;
        bus.IRDY  = 1'b1;
        step(3);
    endtask

    // Monitor: every change of GNT or timeout_pulse pops one expected record.
    initial begin
        exp_t       e;
        logic [2:0] prev_gnt   = 3'b111;
        logic       prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                total++;
                if ($countones(~bus.GNT) > 1) begin
                    bad++;
                    $display("FAIL one_cold edge=%0d gnt=%b required at most one low bit", edge_n, bus.GNT);
                end
                if (bus.GNT !== prev_gnt || timeout_pulse !== prev_pulse) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_event edge=%0d gnt=%b pulse=%b owner=%0d", edge_n, bus.GNT, timeout_pulse, owner);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.edge_no != edge_n || e.gnt !== bus.GNT || e.pulse !== timeout_pulse || e.own !== owner) begin
                            bad++;
                            $display("FAIL event got edge=%0d gnt=%b pulse=%b owner=%0d required edge=%0d gnt=%b pulse=%b owner=%0d",
                                     edge_n, bus.GNT, timeout_pulse, owner, e.edge_no, e.gnt, e.pulse, e.own);
                        end else begin
                            $display("event edge=%0d gnt=%b pulse=%b owner=%0d ok", edge_n, bus.GNT, timeout_pulse, owner);
                        end
                    end
                    prev_gnt   = bus.GNT;
                    prev_pulse = timeout_pulse;
                end
            end
        end
    end

    initial begin
        int t;
        int g;
        RST       = 1'b0;
        bus.REQ   = 3'b111;
        bus.FRAME = 1'b1;
        bus.IRDY  = 1'b1;
        step(3);
        total++;
        if (bus.GNT !== 3'b111 || owner !== 2'd0 || bus_busy !== 1'b0 || timeout_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got gnt=%b owner=%0d busy=%b pulse=%b required 111/0/0/0",
                     bus.GNT, owner, bus_busy, timeout_pulse);
        end else begin
            $display("reset state ok");
        end
        RST    = 1'b1;
        mon_en = 1'b1;

`ifdef PCI_ARB_BUS_PARK_EN
        push(edge_n + 1, 3'b110, 1'b0, 2'd0);
        step(2);
        t = edge_n;
        bus.REQ = 3'b101;
        push(t + 1, 3'b111, 1'b0, 2'd0);
        push(t + 2, 3'b101, 1'b0, 2'd1);
        step(2);
        bus.REQ = 3'b111;
        txn(3, 2'd1, 3'b101, 2'd1);
        t = edge_n;
        bus.REQ = 3'b110;
        push(t + 1, 3'b111, 1'b0, 2'd1);
        push(t + 2, 3'b110, 1'b0, 2'd0);
        step(2);
        t = edge_n;
        bus.REQ = 3'b111;
        push(t + 1, 3'b111, 1'b0, 2'd0);
        push(t + 2, 3'b110, 1'b0, 2'd0);
        step(2);
        step(TO + 4);
`else
        // Contention: all three requesting, three-clock transactions.
        t = edge_n;
        bus.REQ = 3'b000;
        push(t + 1, 3'b110, 1'b0, 2'd0);
        step(1);
        txn(3, 2'd0, 3'b101, 2'd1);
        txn(3, 2'd1, 3'b011, 2'd2);
        txn(3, 2'd2, 3'b110, 2'd0);
        bus.REQ = 3'b111;
        txn(3, 2'd0, 3'b111, 2'd0);

        // Single request from master 0; FRAME two clocks after GNT, IRDY lingers one clock.
        t = edge_n;
        bus.REQ = 3'b110;
        push(t + 1, 3'b110, 1'b0, 2'd0);
        push(t + 8, 3'b111, 1'b0, 2'd0);
        step(2);
        bus.FRAME = 1'b0;
        bus.IRDY  = 1'b0;
        bus.REQ   = 3'b111;
        step(4);
        bus.FRAME = 1'b1;
        total++;
        if (bus_busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_high got %b required 1", bus_busy);
        end
        step(1);
        bus.IRDY = 1'b1;
        step(1);
        total++;
        if (bus_busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_low got %b required 0", bus_busy);
        end
        step(1);

        // Timeout on master 1, then master 2 picks up the bus.
        t = edge_n;
        bus.REQ = 3'b001;
        push(t + 1, 3'b101, 1'b0, 2'd1);
        push(t + TO + 1, 3'b111, 1'b1, 2'd1);
        push(t + TO + 2, 3'b011, 1'b0, 2'd2);
        step(TO + 2);

        // Early release by master 2 leaves the pointer at 0.
        g = edge_n;
        bus.REQ = 3'b111;
        push(g + 1, 3'b111, 1'b0, 2'd2);
        step(1);
        bus.REQ = 3'b010;
        push(g + 2, 3'b110, 1'b0, 2'd0);
        step(1);
        bus.REQ = 3'b111;
        push(g + 3, 3'b111, 1'b0, 2'd0);
        step(1);

        // Reset in the middle of master 1's transaction.
        bus.REQ = 3'b101;
        push(g + 4, 3'b101, 1'b0, 2'd1);
        step(1);
        bus.FRAME = 1'b0;
        bus.IRDY  = 1'b0;
        step(1);
        RST = 1'b0;
        push(g + 6, 3'b111, 1'b0, 2'd0);
        step(1);
        total++;
        if (owner !== 2'd0 || bus_busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got owner=%0d busy=%b required 0/0", owner, bus_busy);
        end
        RST = 1'b1;
        step(4);
        t = edge_n;
        bus.FRAME = 1'b1;
        bus.IRDY  = 1'b1;
        push(t + 1, 3'b101, 1'b0, 2'd1);
        step(1);
        bus.REQ = 3'b111;
        push(t + 2, 3'b111, 1'b0, 2'd1);
        step(1);
`endif

        step(4);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events got %0d pending required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
